// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : ALU execution unit; single-cycle logic/shift/compare/add ops and
//            iterative MUL/DIV/MOD with registered result and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ADD_e,
    input  logic             SUB_e,
    input  logic             MUL_e,
    input  logic             DIV_e,
    input  logic             MOD_e,
    input  logic             MAX_e,
    input  logic             MIN_e,
    input  logic             NOT_e,
    input  logic             NAND_e,
    input  logic             XNOR_e,
    input  logic             SHL_e,
    input  logic             SHRL_e,
    input  logic             ROL_e,
    input  logic             ROR_e,
    input  logic             SLT_e,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             done,
    output logic             busy
);

    localparam int                c_SHW     = $clog2(WIDTH);
    localparam logic [c_SHW-1:0]  c_CNT_MAX = c_SHW'(WIDTH - 1);
    localparam logic [1:0]        c_K_MUL   = 2'd0;
    localparam logic [1:0]        c_K_DIV   = 2'd1;
    localparam logic [1:0]        c_K_MOD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_SHW-1:0]   r_cnt;
    logic [1:0]         r_kind;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;

    logic [14:0]        w_en;
    logic               w_onehot;
    logic [WIDTH-1:0]   w_single;
    logic [c_SHW-1:0]   w_shamt;
    logic [2*WIDTH-1:0] w_rol2;
    logic [2*WIDTH-1:0] w_ror2;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH:0]     w_ddiff;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_x_nx;
    logic [WIDTH-1:0]   w_y_nx;
    logic [WIDTH-1:0]   w_iter_res;
    logic               w_ld;
    logic [WIDTH-1:0]   w_ld_res;
    logic               w_ld_err;
    logic               w_start_iter;

    assign w_en = {SLT_e, ROR_e, ROL_e, SHRL_e, SHL_e, XNOR_e, NAND_e, NOT_e,
                   MIN_e, MAX_e, MOD_e, DIV_e, MUL_e, SUB_e, ADD_e};
    assign w_onehot = (w_en != '0) && ((w_en & (w_en - 15'd1)) == '0);

    // Rotates use a doubled operand so bits shifted out re-enter the other end.
    assign w_shamt = op_b[c_SHW-1:0];
    assign w_rol2  = {op_a, op_a} << w_shamt;
    assign w_ror2  = {op_a, op_a} >> w_shamt;

    always_comb begin
        w_single = '0;
        if (ADD_e)       w_single = op_a + op_b;
        else if (SUB_e)  w_single = op_a - op_b;
        else if (MAX_e)  w_single = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
        else if (MIN_e)  w_single = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
        else if (NOT_e)  w_single = ~op_a;
        else if (NAND_e) w_single = ~(op_a & op_b);
        else if (XNOR_e) w_single = ~(op_a ^ op_b);
        else if (SHL_e)  w_single = op_a << w_shamt;
        else if (SHRL_e) w_single = op_a >> w_shamt;
        else if (ROL_e)  w_single = w_rol2[2*WIDTH-1:WIDTH];
        else if (ROR_e)  w_single = w_ror2[WIDTH-1:0];
        else if (SLT_e)  w_single = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
    end

    // MUL: acc=product, x=multiplicand, y=multiplier.
    // DIV/MOD: acc=partial remainder, x=dividend shifting into quotient, y=divisor.
    assign w_dsh   = {r_acc, r_x[WIDTH-1]};
    assign w_ddiff = w_dsh - {1'b0, r_y};

    always_comb begin
        w_acc_nx = r_acc;
        w_x_nx   = r_x;
        w_y_nx   = r_y;
        if (r_kind == c_K_MUL) begin
            w_acc_nx = r_y[0] ? (r_acc + r_x) : r_acc;
            w_x_nx   = r_x << 1;
            w_y_nx   = r_y >> 1;
        end else if (!w_ddiff[WIDTH]) begin
            w_acc_nx = w_ddiff[WIDTH-1:0];
            w_x_nx   = {r_x[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_nx = w_dsh[WIDTH-1:0];
            w_x_nx   = {r_x[WIDTH-2:0], 1'b0};
        end
    end

    assign w_iter_res = (r_kind == c_K_DIV) ? w_x_nx : w_acc_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_ld         = 1'b0;
        w_ld_res     = '0;
        w_ld_err     = 1'b0;
        w_start_iter = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_onehot) begin
                        w_state_nx = S_DONE;
                        w_ld       = 1'b1;
                        w_ld_err   = 1'b1;
                    end else if (MUL_e) begin
                        w_state_nx   = S_ITER;
                        w_start_iter = 1'b1;
                    end else if (DIV_e || MOD_e) begin
                        if (op_b == '0) begin
                            w_state_nx = S_DONE;
                            w_ld       = 1'b1;
                            w_ld_res   = DIV_e ? '1 : op_a;
                            w_ld_err   = 1'b1;
                        end else begin
                            w_state_nx   = S_ITER;
                            w_start_iter = 1'b1;
                        end
                    end else begin
                        w_state_nx = S_DONE;
                        w_ld       = 1'b1;
                        w_ld_res   = w_single;
                    end
                end
            end
            S_ITER: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_DONE;
                    w_ld       = 1'b1;
                    w_ld_res   = w_iter_res;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
            r_cnt  <= '0;
            r_kind <= c_K_MUL;
            r_acc  <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            if (w_ld) begin
                result <= w_ld_res;
                zero   <= (w_ld_res == '0);
                err    <= w_ld_err;
            end
            if (w_start_iter) begin
                r_acc  <= '0;
                r_x    <= op_a;
                r_y    <= op_b;
                r_cnt  <= c_CNT_MAX;
                r_kind <= MUL_e ? c_K_MUL : (DIV_e ? c_K_DIV : c_K_MOD);
            end else if (r_state == S_ITER) begin
                r_acc <= w_acc_nx;
                r_x   <= w_x_nx;
                r_y   <= w_y_nx;
                r_cnt <= r_cnt - c_SHW'(1);
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

`default_nettype wire
